// File: rtl/active_low_scan_driver.sv
// Four-slot scan driver for an active-low 2-to-4 decoder.
// Each slot is driven for PRESCALE cycles, followed by DEAD enable-low cycles.
module active_low_scan_driver #(
   parameter int PRESCALE = 4,
   parameter int DEAD     = 1
) (
   input  logic        clk,
   input  logic        rst,
   input  logic        run,
   input  logic [15:0] digits,
   input  logic [3:0]  blank,
   output logic [1:0]  w,
   output logic        en,
   output logic [3:0]  digit,
   output logic        frame_done
);

   localparam logic [7:0] ON_LAST  = 8'(PRESCALE - 1);
   localparam logic [7:0] GAP_LAST = 8'((DEAD > 0) ? (DEAD - 1) : 0);

   typedef enum logic [1:0] {
      IDLE,
      ON,
      GAP
   } state_t;

   state_t     state;
   logic [7:0] cnt;
   logic [1:0] next_w;
   logic [3:0] next_digit;
   logic       next_blank;

   // Slot that follows the current one, and its value/blank bit
   always_comb begin
      next_w     = w + 2'd1;
      next_digit = digits[{next_w, 2'b00} +: 4];
      next_blank = blank[next_w];
   end

   // Scan sequencer; the blank bit is held via en, latched on ON entry
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         state      <= IDLE;
         cnt        <= '0;
         w          <= '0;
         en         <= 1'b0;
         digit      <= '0;
         frame_done <= 1'b0;
      end else begin
         frame_done <= 1'b0;
         if (!run) begin
            state <= IDLE;
            cnt   <= '0;
            w     <= '0;
            en    <= 1'b0;
         end else begin
            case (state)
               IDLE: begin
                  state <= ON;
                  cnt   <= '0;
                  w     <= '0;
                  digit <= digits[3:0];
                  en    <= ~blank[0];
               end
               ON: begin
                  if (cnt == ON_LAST) begin
                     cnt <= '0;
                     if (DEAD > 0) begin
                        state <= GAP;
                        en    <= 1'b0;
                     end else begin
                        state      <= ON;
                        w          <= next_w;
                        digit      <= next_digit;
                        en         <= ~next_blank;
                        frame_done <= (w == 2'd3);
                     end
                  end else begin
                     cnt <= cnt + 8'd1;
                  end
               end
               GAP: begin
                  if (cnt == GAP_LAST) begin
                     state      <= ON;
                     cnt        <= '0;
                     w          <= next_w;
                     digit      <= next_digit;
                     en         <= ~next_blank;
                     frame_done <= (w == 2'd3);
                  end else begin
                     cnt <= cnt + 8'd1;
                  end
               end
               default: begin
                  state <= IDLE;
                  cnt   <= '0;
                  w     <= '0;
                  en    <= 1'b0;
               end
            endcase
         end
      end
   end

endmodule

// File: tb/tb_active_low_scan_driver.sv
// Bench for active_low_scan_driver: two instances (4/1 and 3/0) share stimulus
// and are compared every cycle against a time-index reference model.
module tb_active_low_scan_driver;

   logic        clk = 1'b0;
   logic        rst;
   logic        run;
   logic [15:0] digits;
   logic [3:0]  blank;

   logic [1:0]  w_a, w_b;
   logic        en_a, en_b;
   logic [3:0]  digit_a, digit_b;
   logic        fd_a, fd_b;

   int errors = 0;
   int checks = 0;

   always #5 clk = ~clk;

   active_low_scan_driver #(.PRESCALE(4), .DEAD(1)) dut_a (
      .clk(clk), .rst(rst), .run(run), .digits(digits), .blank(blank),
      .w(w_a), .en(en_a), .digit(digit_a), .frame_done(fd_a)
   );

   active_low_scan_driver #(.PRESCALE(3), .DEAD(0)) dut_b (
      .clk(clk), .rst(rst), .run(run), .digits(digits), .blank(blank),
      .w(w_b), .en(en_b), .digit(digit_b), .frame_done(fd_b)
   );

   // Reference model: position inside the frame as a plain cycle index
   int P [2] = '{4, 3};
   int D [2] = '{1, 0};
   int t     [2];
   bit act   [2];
   int m_w   [2];
   int m_en  [2];
   int m_dig [2];
   int m_fd  [2];
   int m_blk [2];

   task automatic check(input string tag, input int got, input int exp);
      checks++;
      if (got !== exp) begin
         errors++;
         $display("FAIL %s: got %0d expected %0d at %0t", tag, got, exp, $time);
      end
   endtask

   task automatic model_reset();
      for (int k = 0; k < 2; k++) begin
         act[k] = 0; t[k] = 0; m_w[k] = 0; m_en[k] = 0;
         m_dig[k] = 0; m_fd[k] = 0; m_blk[k] = 0;
      end
   endtask

   task automatic model_step();
      int slot, ph, per;
      for (int k = 0; k < 2; k++) begin
         per = P[k] + D[k];
         if (!run) begin
            act[k] = 0; t[k] = 0; m_w[k] = 0; m_en[k] = 0; m_fd[k] = 0;
         end else begin
            if (!act[k]) begin
               act[k] = 1; t[k] = 0; m_fd[k] = 0;
            end else begin
               t[k] = (t[k] + 1) % (4 * per);
               m_fd[k] = (t[k] == 0);
            end
            slot = t[k] / per;
            ph   = t[k] % per;
            if (ph == 0) begin
               m_dig[k] = int'((digits >> (4 * slot)) & 16'hF);
               m_blk[k] = int'(blank[slot]);
            end
            m_w[k]  = slot;
            m_en[k] = ((ph < P[k]) && (m_blk[k] == 0)) ? 1 : 0;
         end
      end
   endtask

   task automatic check_all();
      check("w_a",     int'(w_a),     m_w[0]);
      check("en_a",    int'(en_a),    m_en[0]);
      check("digit_a", int'(digit_a), m_dig[0]);
      check("fd_a",    int'(fd_a),    m_fd[0]);
      check("w_b",     int'(w_b),     m_w[1]);
      check("en_b",    int'(en_b),    m_en[1]);
      check("digit_b", int'(digit_b), m_dig[1]);
      check("fd_b",    int'(fd_b),    m_fd[1]);
   endtask

   task automatic cycle();
      @(posedge clk);
      if (rst) model_reset();
      else     model_step();
      #1;
      check_all();
   endtask

   task automatic async_reset();
      #2;
      rst = 1'b1;
      #1;
      model_reset();
      check_all();
   endtask

   initial begin
      rst    = 1'b1;
      run    = 1'b0;
      digits = 16'h4321;
      blank  = 4'b0000;
      model_reset();
      #2;
      check_all();
      check("reset_digit_a", int'(digit_a), 0);

      // Release reset, scan a full frame of 4321
      @(negedge clk);
      rst = 1'b0;
      run = 1'b1;
      repeat (21) cycle();
      check("frame_done_at_20", int'(fd_a), 1);
      check("w_wrap_at_20", int'(w_a), 0);
      check("digit_wrap_at_20", int'(digit_a), 1);

      // Blank slot 2
      blank = 4'b0100;
      repeat (20) cycle();

      // Digits change mid slot 0
      blank = 4'b0000;
      run = 1'b0;
      cycle();
      run = 1'b1;
      repeat (2) cycle();
      digits = 16'hFFFF;
      repeat (4) cycle();
      check("new_digit_slot1", int'(digit_a), 15);

      // Stop during slot 1, then restart
      digits = 16'h4321;
      repeat (2) cycle();
      run = 1'b0;
      cycle();
      check("stop_en", int'(en_a), 0);
      run = 1'b1;
      repeat (6) cycle();

      // Asynchronous reset mid slot, then release with run high
      async_reset();
      cycle();
      rst = 1'b0;
      repeat (5) cycle();

      // Randomized phase
      for (int i = 0; i < 800; i++) begin
         if (rst) begin
            rst = 1'b0;
         end else if ($urandom_range(0, 99) == 0) begin
            async_reset();
         end
         run = ($urandom_range(0, 24) != 0);
         if ($urandom_range(0, 3) == 0) digits = 16'($urandom);
         if ($urandom_range(0, 7) == 0)
            blank = ($urandom_range(0, 1) == 0) ? 4'b0000 : 4'($urandom_range(0, 15));
         cycle();
      end

      $display("Result: errors=%0d of %0d checks", errors, checks);
      $finish;
   end

endmodule
